// File: rtl/img_proc_pkg.sv
// Shared image-pipeline definitions: sequencer states, default frame size, coordinate widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package img_proc_pkg;

  localparam int DEF_IMG_WIDTH  = 176;
  localparam int DEF_IMG_HEIGHT = 176;
  localparam int COL_W          = 10;
  localparam int ROW_W          = 9;

  // Sequencer states kept as plain constants so older blocks can compare raw codes.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_FILL   = 2'd1;
  localparam state_t ST_STREAM = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/xy_counter.sv
// Column/row position of the next accepted pixel; col wraps into row, row wraps to 0.
// Latency: position advances on the clock edge after inc.
// Backpressure: none; inc only when a pixel is accepted, clr has priority.
// Ports: pclk/reset (sync, active-high), clr, inc -> col, row, last (at final pixel).
module xy_counter
  import img_proc_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last
);

  logic col_end;
  logic row_end;

  assign col_end = (col == COL_W'(IMG_WIDTH - 1));
  assign row_end = (row == ROW_W'(IMG_HEIGHT - 1));
  assign last    = col_end && row_end;

  always_ff @(posedge pclk) begin
    if (reset || clr) begin
      col <= '0;
      row <= '0;
    end else if (inc) begin
      if (col_end) begin
        col <= '0;
        // Wrapping the row too leaves the counter parked at (0,0) after a frame.
        row <= row_end ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/window_seq_ctrl.sv
// 3x3 window sequencer: drives line-FIFO strobes and flags complete interior windows.
// Latency: FIFO strobes combinational; win_valid 2 cycles after the source pixel.
// Backpressure: none; pixels are accepted whenever pix_valid is high in FILL/STREAM.
// Ports: pclk, reset (sync, active-high), frame_start, pix_valid -> l3/l2/l1 wr/rd,
//        fifo_sclr, win_valid/win_col/win_row, frame_done, busy, and err when
//        WIN_SEQ_ERR_EN is defined (sticky protocol-error flag).
module window_seq_ctrl
  import img_proc_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             pix_valid,
  output logic             l3_wr,
  output logic             l3_rd,
  output logic             l2_wr,
  output logic             l2_rd,
  output logic             l1_wr,
  output logic             l1_rd,
  output logic             fifo_sclr,
  output logic             win_valid,
  output logic [COL_W-1:0] win_col,
  output logic [ROW_W-1:0] win_row,
  output logic             frame_done,
`ifdef WIN_SEQ_ERR_EN
  output logic             err,
`endif
  output logic             busy
);

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             last;
  logic             in_frame;
  logic             restart;
  logic             accepted;
  logic             cnt_clr;

  // First stage: pixel accepted, FIFO data arriving; second stage: window registers loaded.
  logic             s1_vld;
  logic [COL_W-1:0] s1_col;
  logic [ROW_W-1:0] s1_row;
  logic             s2_vld;
  logic [COL_W-1:0] s2_col;
  logic [ROW_W-1:0] s2_row;

  assign in_frame = (state == ST_FILL) || (state == ST_STREAM);
  // Any frame_start outside IDLE abandons the current frame; its pixel is dropped.
  assign restart  = !reset && frame_start && (state != ST_IDLE);
  assign accepted = !reset && pix_valid &&
                    ((in_frame && !frame_start) || (state == ST_IDLE && frame_start));
  // Hold the counters at zero while idle so a new frame always starts at (0,0).
  assign cnt_clr  = restart || (state == ST_IDLE && !frame_start);

  assign l3_wr     = accepted;
  assign l3_rd     = accepted;
  assign l2_wr     = accepted;
  assign l2_rd     = accepted && (row != '0);
  assign l1_wr     = accepted && (row != '0);
  assign l1_rd     = accepted && (row >= ROW_W'(2));
  assign fifo_sclr = reset || restart;

  assign busy       = !reset && (state != ST_IDLE);
  assign frame_done = !reset && (state == ST_DONE);
  assign win_valid  = !reset && s2_vld;
  assign win_col    = reset ? '0 : s2_col;
  assign win_row    = reset ? '0 : s2_row;

  xy_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_xy (
    .pclk (pclk),
    .reset(reset),
    .clr  (cnt_clr),
    .inc  (accepted),
    .col  (col),
    .row  (row),
    .last (last)
  );

  always_ff @(posedge pclk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (restart) begin
      state <= ST_FILL;
    end else begin
      case (state)
        ST_IDLE:   if (frame_start) state <= ST_FILL;
        ST_FILL:   if (row == ROW_W'(2)) state <= ST_STREAM;
        ST_STREAM: if (accepted && last) state <= ST_DONE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (reset || restart) begin
      s1_vld <= 1'b0;
      s1_col <= '0;
      s1_row <= '0;
      s2_vld <= 1'b0;
      s2_col <= '0;
      s2_row <= '0;
    end else begin
      // Window is complete once the bottom-right pixel of a 3x3 block arrives;
      // its centre sits one up and one left.
      if (accepted && row >= ROW_W'(2) && col >= COL_W'(2)) begin
        s1_vld <= 1'b1;
        s1_col <= col - COL_W'(1);
        s1_row <= row - ROW_W'(1);
      end else begin
        s1_vld <= 1'b0;
        s1_col <= '0;
        s1_row <= '0;
      end
      s2_vld <= s1_vld;
      s2_col <= s1_col;
      s2_row <= s1_row;
    end
  end

`ifdef WIN_SEQ_ERR_EN
  logic err_q;

  always_ff @(posedge pclk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((state == ST_DONE && pix_valid) || (in_frame && frame_start)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_window_seq_ctrl.sv
// Randomized scoreboard bench for window_seq_ctrl (4x4 instance plus default 176x176 instance).
// Latency: expected windows are queued with the cycle they are due.
// Backpressure: n/a.
module tb_window_seq_ctrl;
  import img_proc_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  logic pclk = 1'b0;
  logic reset = 1'b1;
  logic frame_start = 1'b0;
  logic pix_valid = 1'b0;
  logic l3_wr, l3_rd, l2_wr, l2_rd, l1_wr, l1_rd, fifo_sclr, win_valid, frame_done, busy;
  logic [COL_W-1:0] win_col;
  logic [ROW_W-1:0] win_row;
`ifdef WIN_SEQ_ERR_EN
  logic err, b_err;
`endif

  logic fs_b = 1'b0;
  logic pv_b = 1'b0;
  logic b_l3_wr, b_l3_rd, b_l2_wr, b_l2_rd, b_l1_wr, b_l1_rd, b_sclr, b_win_valid, b_done, b_busy;
  logic [COL_W-1:0] b_win_col;
  logic [ROW_W-1:0] b_win_row;

  always #5 pclk = ~pclk;

  window_seq_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .pclk(pclk), .reset(reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .l3_wr(l3_wr), .l3_rd(l3_rd), .l2_wr(l2_wr), .l2_rd(l2_rd), .l1_wr(l1_wr), .l1_rd(l1_rd),
    .fifo_sclr(fifo_sclr), .win_valid(win_valid), .win_col(win_col), .win_row(win_row),
    .frame_done(frame_done),
`ifdef WIN_SEQ_ERR_EN
    .err(err),
`endif
    .busy(busy)
  );

  window_seq_ctrl dut_big (
    .pclk(pclk), .reset(reset), .frame_start(fs_b), .pix_valid(pv_b),
    .l3_wr(b_l3_wr), .l3_rd(b_l3_rd), .l2_wr(b_l2_wr), .l2_rd(b_l2_rd), .l1_wr(b_l1_wr),
    .l1_rd(b_l1_rd), .fifo_sclr(b_sclr), .win_valid(b_win_valid), .win_col(b_win_col),
    .win_row(b_win_row), .frame_done(b_done),
`ifdef WIN_SEQ_ERR_EN
    .err(b_err),
`endif
    .busy(b_busy)
  );

  typedef struct {
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    int               due;
  } win_t;

  win_t exp_q[$];
  win_t mon_e;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  // Reference model: frame phase (0 idle, 1 in frame, 2 done), pixel index within frame.
  int   phase   = 0;
  int   idx     = 0;
  logic err_exp = 1'b0;

  int   big_cnt = 0;
  int   big_col = 0;
  int   big_row = 0;

  always @(posedge pclk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drop expected windows the DUT will never emit (pipeline flushed).
  task automatic flush_from(input int first_due);
    while (exp_q.size() > 0 && exp_q[$].due >= first_due) void'(exp_q.pop_back());
  endtask

  task automatic step(input logic fs, input logic pv);
    logic       acc;
    int         col, row;
    logic [5:0] ef;
    frame_start = fs;
    pix_valid   = pv;
    @(negedge pclk);
    col = idx % W;
    row = idx / W;
    acc = !reset && pv && ((phase == 1 && !fs) || (phase == 0 && fs));
    ef  = {acc, acc, acc, acc && row >= 1, acc && row >= 1, acc && row >= 2};
    check("fifo_req", {26'd0, l3_wr, l3_rd, l2_wr, l2_rd, l1_wr, l1_rd}, {26'd0, ef});
    check("fifo_sclr", {31'd0, fifo_sclr}, {31'd0, reset || (fs && phase != 0)});
    check("busy", {31'd0, busy}, {31'd0, !reset && phase != 0});
    check("frame_done", {31'd0, frame_done}, {31'd0, !reset && phase == 2});
`ifdef WIN_SEQ_ERR_EN
    check("err", {31'd0, err}, {31'd0, !reset && err_exp});
`endif
    if (reset) begin
      phase   = 0;
      idx     = 0;
      err_exp = 1'b0;
      flush_from(cyc);
    end else begin
      if ((phase == 2 && pv) || (phase == 1 && fs)) err_exp = 1'b1;
      if (fs && phase != 0) begin
        phase = 1;
        idx   = 0;
        flush_from(cyc + 1);
      end else begin
        if (phase == 2) phase = 0;
        else if (phase == 0 && fs) phase = 1;
        if (acc) begin
          if (col >= 2 && row >= 2)
            exp_q.push_back('{col: COL_W'(col - 1), row: ROW_W'(row - 1), due: cyc + 2});
          if (idx == W * H - 1) begin
            phase = 2;
            idx   = 0;
          end else begin
            idx++;
          end
        end
      end
    end
    @(posedge pclk);
    #1;
  endtask

  // Monitor: every presented window must match the oldest expected one, on time.
  always @(negedge pclk) begin
    if (win_valid) begin
      if (exp_q.size() == 0) begin
        check("win_unexpected", {22'd0, win_col}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("win_col", {22'd0, win_col}, {22'd0, mon_e.col});
        check("win_row", {23'd0, win_row}, {23'd0, mon_e.row});
        check("win_cycle", cyc, mon_e.due);
      end
    end else begin
      check("win_coord_idle", {13'd0, win_col, win_row}, 32'd0);
    end
  end

  always @(negedge pclk) begin
    if (b_win_valid) begin
      big_cnt++;
      big_col = int'(b_win_col);
      big_row = int'(b_win_row);
    end
  end

  initial begin
    // Reset held three cycles, then released.
    repeat (3) step(1'b0, 1'b0);
    reset = 1'b0;
    step(1'b0, 1'b0);

    // Back-to-back frame.
    step(1'b1, 1'b1);
    repeat (15) step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0);

    // Same frame, pix_valid every other cycle.
    step(1'b1, 1'b1);
    repeat (15) begin
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
    end
    repeat (4) step(1'b0, 1'b0);

    // Restart after pixel 9, then a full frame.
    step(1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (16) step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0);

    // pix_valid held through IDLE and DONE.
    repeat (3) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (15) step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Randomized traffic with occasional restarts and resets.
    repeat (800) begin
      reset = ($urandom_range(0, 249) == 0);
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
    end
    reset = 1'b0;
    repeat (6) step(1'b0, 1'b0);
    check("scoreboard_empty", exp_q.size(), 0);

    // Default-size frame on the second instance.
    fs_b = 1'b1;
    pv_b = 1'b1;
    @(posedge pclk);
    #1;
    fs_b = 1'b0;
    repeat (176 * 176 - 1) @(posedge pclk);
    #1;
    pv_b = 1'b0;
    repeat (5) @(posedge pclk);
    #1;
    check("big_win_count", big_cnt, 30276);
    check("big_last_col", big_col, 174);
    check("big_last_row", big_row, 174);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/window_seq_ctrl.md
WINDOW_SEQ_CTRL -- requirements
Module: window_seq_ctrl

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 176, pixels per line (>=3).
REQ-002 SHALL have parameter IMG_HEIGHT, default 176, lines per frame (>=3).
REQ-003 SHALL have port pclk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port frame_start, input, 1, pulse marking the first pixel of a new frame.
REQ-006 SHALL have port pix_valid, input, 1, source pixel accepted this cycle.
REQ-007 SHALL have port l3_wr, l3_rd, l2_wr, l2_rd, l1_wr, l1_rd, outputs, 1 each, line-FIFO write/read requests.
REQ-008 SHALL have port fifo_sclr, output, 1, synchronous clear for all three line FIFOs.
REQ-009 SHALL have port win_valid, output, 1, 3x3 window registers hold a complete interior window.
REQ-010 SHALL have ports win_col (10 bits) and win_row (9 bits), outputs, centre-pixel coordinates of the valid window.
REQ-011 SHALL have port frame_done, output, 1, one-cycle pulse after last pixel of frame.
REQ-012 SHALL have port busy, output, 1, high in any state except IDLE.

Function
REQ-013 SHALL implement states IDLE, FILL, STREAM, DONE.
REQ-014 SHALL transition IDLE->FILL on frame_start; FILL->STREAM when row counter reaches 2; STREAM->DONE on accepted pixel at (IMG_WIDTH-1, IMG_HEIGHT-1); DONE->IDLE unconditionally after one cycle.
REQ-015 SHALL count only accepted pixels (pix_valid high in FILL/STREAM, or on the frame_start cycle); col wraps IMG_WIDTH-1->0 and increments row.
REQ-016 SHALL drive combinationally: l3_wr=l3_rd=l2_wr=accepted; l2_rd=l1_wr=accepted AND row>=1; l1_rd=accepted AND row>=2.
REQ-017 SHALL assert win_valid exactly 2 cycles after an accepted pixel at row>=2 and col>=2 (1 cycle FIFO read latency + 1 cycle window register).
REQ-018 SHALL present win_col=col-1, win_row=row-1 of that pixel, aligned with win_valid; both zero when win_valid low.
REQ-019 SHALL produce (IMG_WIDTH-2)*(IMG_HEIGHT-2) win_valid pulses per complete frame.
REQ-020 SHALL ignore pix_valid in IDLE and DONE (no FIFO requests, no counting).
REQ-021 SHALL, on frame_start while busy, pulse fifo_sclr for one cycle, zero counters, flush the win_valid pipeline, and enter FILL; the pixel on that cycle is not accepted.
REQ-022 SHALL assert frame_done in the DONE state only.

Reset
REQ-023 SHALL, while reset high, force state IDLE, counters zero, all outputs 0 except fifo_sclr=1.
REQ-024 SHALL give reset priority over frame_start and pix_valid.

Configuration
REQ-025 SHALL compile, when WIN_SEQ_ERR_EN is defined, an extra output err (1 bit, sticky until reset) set on pix_valid in DONE or on mid-frame frame_start.
REQ-026 SHALL, without WIN_SEQ_ERR_EN, have no err port and no error logic; all other behaviour identical.

Structure
REQ-027 SHALL take the state enum, default IMG_WIDTH/IMG_HEIGHT and coordinate widths from shared package img_proc_pkg.
REQ-028 SHALL place col/row wrap counting in one sub-module, xy_counter.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4 unless noted)
REQ-029 SHALL check: reset 3 cycles -> state IDLE, fifo_sclr=1, all others 0; release -> fifo_sclr=0.
REQ-030 SHALL check: frame_start + 16 back-to-back pix_valid -> l1_rd count 8, l2_rd count 12, win_valid 4 pulses with (col,row) = (1,1),(2,1),(1,2),(2,2), frame_done one cycle after 16th pixel.
REQ-031 SHALL check: same frame with pix_valid toggling every other cycle -> same 4 windows, each 2 cycles after its source pixel.
REQ-032 SHALL check: frame_start after pixel 9 -> fifo_sclr one cycle, counters zero, next 16 pixels produce exactly 4 windows.
REQ-033 SHALL check: pix_valid held high in IDLE and DONE -> no FIFO requests; with WIN_SEQ_ERR_EN, err set in DONE and held.
REQ-034 SHALL check: default 176x176 frame -> 30276 win_valid pulses, last at (174,174).
